pwm_snd_decoder: RTL and testbench
==================================

# pwm_snd_decoder

Receive-side counterpart to the design's PWM audio output: recovers PCM samples from a 1-bit PWM/square-wave audio stream by measuring duty cycle over fixed frames of clock cycles. Also reports rising-edge count per frame as a coarse frequency measure. Used as a loopback checker and analyzer on the audio pin. Delivers each frame result through a valid/ready handshake with a sticky overrun flag.

## Interface

Parameters:
- FRAME_BITS, 8: log2 of frame length in clocks. Frame length is 2^FRAME_BITS cycles.
- SAMPLE_BITS, 8: output sample width. Legal range is 1..FRAME_BITS.
- SYNC_STAGES, 2: synchronizer depth on snd_in. Minimum 2.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous, active-high.
- snd_in, input, 1: PWM audio input. Asynchronous to clk.
- sample_out, output, SAMPLE_BITS: duty-cycle sample for the last completed frame.
- edges_out, output, FRAME_BITS: rising edges seen in that frame.
- sample_valid, output, 1: sample_out and edges_out hold an unconsumed result.
- sample_ready, input, 1: the consumer accepts the result in this cycle.
- overrun, output, 1: sticky flag. Set when a completed frame result had to be discarded.
- clear_overrun, input, 1: clears overrun.

## Operation

- **Synchronizer.** snd_in passes through SYNC_STAGES flops to produce s. All stages reset to 0.
- **Edge detect.** s_prev is s delayed one cycle, reset to 0. A rise is s & ~s_prev.
- **Frame counter.** frame_cnt is FRAME_BITS wide, reset to 0, and increments every cycle, wrapping at 2^FRAME_BITS-1 → 0. The cycle with frame_cnt == 2^FRAME_BITS-1 is the frame's last cycle.
- **High count.**
  - hi_cnt is FRAME_BITS+1 wide and accumulates s each cycle.
  - On the last cycle, the frame total is hi_cnt + s, with range 0..2^FRAME_BITS.
  - hi_cnt then restarts at 0.
- **Sample.**
  - Saturate the total to 2^FRAME_BITS-1.
  - sample = saturated total[FRAME_BITS-1 : FRAME_BITS-SAMPLE_BITS], i.e. truncation with no rounding.
- **Edge count.**
  - edge_cnt is FRAME_BITS wide and accumulates rises.
  - The frame total is edge_cnt + rise, saturating at 2^FRAME_BITS-1 (unreachable in practice, max 2^(FRAME_BITS-1)).
  - edge_cnt then restarts at 0.
- **Output state machine.** Two states, EMPTY (sample_valid=0) and FULL (sample_valid=1).
  - EMPTY + frame end: load result → FULL.
  - FULL + sample_ready, no frame end: → EMPTY.
  - FULL + sample_ready + frame end (same cycle): old result consumed, new result loaded, stay FULL, no overrun.
  - FULL + no sample_ready + frame end: new result discarded, old result held, overrun ← 1.
  - sample_ready while EMPTY is ignored.
- **Overrun.**
  - clear_overrun clears the flag.
  - Simultaneous set and clear: set wins.
- **Output stability.** sample_out and edges_out change only on a load and are stable while FULL.
- **Reset.**
  - All outputs reset: sample_out=0, edges_out=0, sample_valid=0, overrun=0.
  - frame_cnt, hi_cnt and edge_cnt reset to 0.
  - Reset mid-frame discards the partial frame. Counting restarts with frame_cnt=0 on the first cycle after reset deasserts.

## Timing

- snd_in to s latency: SYNC_STAGES cycles.
- Result registered at the clock edge ending the frame's last cycle. sample_valid is high in the following cycle.
- The first frame covers cycles 0..2^FRAME_BITS-1 after reset release. sample_valid first rises in cycle 2^FRAME_BITS.
- The first SYNC_STAGES cycles of frame 0 see s=0 (synchronizer flush).
- Handshake transfer occurs on any cycle with sample_valid & sample_ready. sample_valid falls the next cycle unless a new frame loaded in the same cycle.
- Throughput: one result per 2^FRAME_BITS cycles. The consumer has a full frame to accept before overrun.

## Structure

- Shared package holds:
  - the output state encoding (EMPTY/FULL);
  - a localparam helper for frame length (1 << FRAME_BITS).
- One sub-module, pwm_snd_sync: SYNC_STAGES-deep synchronizer plus s_prev and rise output.
- Frame counters, saturation and the handshake live in pwm_snd_decoder.

## Test plan

Defaults for all scenarios: FRAME_BITS=8, SAMPLE_BITS=8, SYNC_STAGES=2, sample_ready=1 unless stated.

- **Constant low.** snd_in=0 for 3 frames → each result sample_out=0x00, edges_out=0. First sample_valid in cycle 256.
- **Constant high.** snd_in=1 from reset release:
  - frame 0 total 254 → sample_out=0xFE, edges_out=1;
  - frame 1 total 256 saturates → sample_out=0xFF, edges_out=0.
- **50% square wave.** Period 4 clocks (2 high, 2 low), steady state → sample_out=0x80, edges_out=64 every frame.
- **Backpressure.** sample_ready=0 across 2 frame ends → first result held unchanged, overrun=1 after the second frame end. Then:
  - sample_ready=1 → result consumed, sample_valid falls;
  - clear_overrun → overrun=0;
  - clear_overrun asserted in the same cycle as a new overrun → overrun stays 1.
- **Same-cycle accept and load.** sample_ready pulsed exactly on the frame-end cycle while FULL → sample_valid stays 1, new values appear next cycle, overrun stays 0.
- **Reset mid-frame.** Assert reset at frame_cnt=100 with snd_in=1 → all outputs 0. Next sample_valid 256 cycles after release, containing no pre-reset contribution.

Source files
------------

// File: rtl/pwm_snd_decoder_pkg.sv
// Shared types and helpers for the PWM audio receive-side decoder.
package pwm_snd_decoder_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Frame length in clocks for a given log2 frame size.
  function automatic int unsigned frame_len(input int unsigned frame_bits);
    return 32'd1 << frame_bits;
  endfunction

endpackage

// File: rtl/pwm_snd_decoder_if.sv
// Result handshake between the decoder (master) and its consumer (slave).
interface pwm_snd_decoder_if #(
  parameter int unsigned FRAME_BITS  = 8,
  parameter int unsigned SAMPLE_BITS = 8
);

  logic [SAMPLE_BITS-1:0] sample_out;
  logic [FRAME_BITS-1:0]  edges_out;
  logic                   sample_valid;
  logic                   sample_ready;
  logic                   overrun;
  logic                   clear_overrun;

  modport master (
    output sample_out,
    output edges_out,
    output sample_valid,
    output overrun,
    input  sample_ready,
    input  clear_overrun
  );

  modport slave (
    input  sample_out,
    input  edges_out,
    input  sample_valid,
    input  overrun,
    output sample_ready,
    output clear_overrun
  );

endinterface

// File: rtl/pwm_snd_sync.sv
// Multi-flop synchronizer for the asynchronous audio pin plus rising-edge detect.
module pwm_snd_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic snd_in,
  output logic s,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], snd_in};
      s_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign rise_c = s & ~s_prev;

endmodule

// File: rtl/pwm_snd_decoder.sv
// Recovers PCM samples and rising-edge counts from a 1-bit PWM audio stream,
// one result per frame, delivered over a valid/ready handshake with sticky overrun.
module pwm_snd_decoder
  import pwm_snd_decoder_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = 8,
  parameter int unsigned SAMPLE_BITS = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               snd_in,
  pwm_snd_decoder_if.master  bus
);

  localparam int unsigned FRAME_LEN = frame_len(FRAME_BITS);
  localparam logic [FRAME_BITS-1:0] FRAME_LAST = FRAME_BITS'(FRAME_LEN - 1);

  logic                   s;
  logic                   rise_c;
  logic [FRAME_BITS-1:0]  frame_cnt;
  logic [FRAME_BITS:0]    hi_cnt;
  logic [FRAME_BITS-1:0]  edge_cnt;

  logic                   frame_end_c;
  logic [FRAME_BITS:0]    hi_total_c;
  logic [FRAME_BITS-1:0]  hi_sat_c;
  logic [SAMPLE_BITS-1:0] sample_c;
  logic [FRAME_BITS:0]    edge_total_c;
  logic [FRAME_BITS-1:0]  edge_sat_c;

  out_state_e             state;
  logic [SAMPLE_BITS-1:0] sample_q;
  logic [FRAME_BITS-1:0]  edges_q;
  logic                   overrun_q;

  pwm_snd_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .snd_in (snd_in),
    .s      (s),
    .rise_c (rise_c)
  );

  // Frame totals include the last cycle's contribution; only a full-high
  // frame reaches 2^FRAME_BITS, which saturates to all ones.
  always_comb begin
    frame_end_c  = (frame_cnt == FRAME_LAST);
    hi_total_c   = hi_cnt + (FRAME_BITS+1)'(s);
    hi_sat_c     = hi_total_c[FRAME_BITS] ? '1 : hi_total_c[FRAME_BITS-1:0];
    sample_c     = hi_sat_c[FRAME_BITS-1 -: SAMPLE_BITS];
    edge_total_c = {1'b0, edge_cnt} + (FRAME_BITS+1)'(rise_c);
    edge_sat_c   = edge_total_c[FRAME_BITS] ? '1 : edge_total_c[FRAME_BITS-1:0];
  end

  // Frame, high-level and edge accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      hi_cnt    <= '0;
      edge_cnt  <= '0;
    end else begin
      frame_cnt <= frame_cnt + FRAME_BITS'(1);
      hi_cnt    <= frame_end_c ? '0 : hi_total_c;
      edge_cnt  <= frame_end_c ? '0 : edge_total_c[FRAME_BITS-1:0];
    end
  end

  // Output holding register; a frame end while FULL and not accepted drops
  // the new result and raises overrun, with set taking priority over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_EMPTY;
      sample_q  <= '0;
      edges_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (bus.clear_overrun) overrun_q <= 1'b0;
      unique case (state)
        ST_EMPTY: begin
          if (frame_end_c) begin
            sample_q <= sample_c;
            edges_q  <= edge_sat_c;
            state    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (frame_end_c) begin
            if (bus.sample_ready) begin
              sample_q <= sample_c;
              edges_q  <= edge_sat_c;
            end else begin
              overrun_q <= 1'b1;
            end
          end else if (bus.sample_ready) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.sample_out   = sample_q;
  assign bus.edges_out    = edges_q;
  assign bus.sample_valid = (state == ST_FULL);
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_pwm_snd_decoder.sv
// Directed self-checking bench for pwm_snd_decoder (FRAME_BITS=8, SAMPLE_BITS=8, SYNC_STAGES=2).
module tb_pwm_snd_decoder;

  logic       clk;
  logic       reset;
  logic       snd_in;
  logic       snd_lvl;
  logic       sq_en;
  logic [7:0] sq_cnt;
  int         cyc;
  int         checks;
  int         errors;

  pwm_snd_decoder_if #(.FRAME_BITS(8), .SAMPLE_BITS(8)) bus ();

  pwm_snd_decoder #(
    .FRAME_BITS  (8),
    .SAMPLE_BITS (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .snd_in (snd_in),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square wave source: period 4 clocks, 2 high / 2 low.
  initial sq_cnt = 8'd0;
  always @(negedge clk) sq_cnt <= sq_cnt + 8'd1;
  assign snd_in = sq_en ? sq_cnt[1] : snd_lvl;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic goto(input int t);
    step(t - cyc);
  endtask

  // Returns in cycle 0 (frame_cnt == 0) of the first frame after release.
  task automatic do_reset(input logic lvl, input logic rdy);
    snd_lvl              = lvl;
    sq_en                = 1'b0;
    bus.sample_ready     = rdy;
    bus.clear_overrun    = 1'b0;
    reset                = 1'b1;
    step(3);
    reset                = 1'b0;
    cyc                  = 0;
  endtask

  task automatic test_reset();
    reset             = 1'b1;
    snd_lvl           = 1'b0;
    sq_en             = 1'b0;
    bus.sample_ready  = 1'b0;
    bus.clear_overrun = 1'b0;
    step(3);
    checks++; if (bus.sample_out !== 8'h00) begin errors++; $display("FAIL rst_sample: got %h expected 00", bus.sample_out); end
    checks++; if (bus.edges_out !== 8'd0) begin errors++; $display("FAIL rst_edges: got %0d expected 0", bus.edges_out); end
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.sample_valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", bus.overrun); end
  endtask

  task automatic test_const_low();
    do_reset(1'b0, 1'b1);
    goto(255);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL low_valid_early: got %b expected 0", bus.sample_valid); end
    for (int f = 1; f <= 3; f++) begin
      goto(256 * f);
      checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL low_f%0d_valid: got %b expected 1", f, bus.sample_valid); end
      checks++; if (bus.sample_out !== 8'h00) begin errors++; $display("FAIL low_f%0d_sample: got %h expected 00", f, bus.sample_out); end
      checks++; if (bus.edges_out !== 8'd0) begin errors++; $display("FAIL low_f%0d_edges: got %0d expected 0", f, bus.edges_out); end
    end
    goto(257 * 1 + 512);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL low_valid_fall: got %b expected 0", bus.sample_valid); end
  endtask

  task automatic test_const_high();
    do_reset(1'b1, 1'b1);
    goto(256);
    checks++; if (bus.sample_out !== 8'hFE) begin errors++; $display("FAIL high_f0_sample: got %h expected fe", bus.sample_out); end
    checks++; if (bus.edges_out !== 8'd1) begin errors++; $display("FAIL high_f0_edges: got %0d expected 1", bus.edges_out); end
    goto(512);
    checks++; if (bus.sample_out !== 8'hFF) begin errors++; $display("FAIL high_f1_sample: got %h expected ff", bus.sample_out); end
    checks++; if (bus.edges_out !== 8'd0) begin errors++; $display("FAIL high_f1_edges: got %0d expected 0", bus.edges_out); end
  endtask

  task automatic test_square();
    do_reset(1'b0, 1'b1);
    sq_en = 1'b1;
    for (int f = 2; f <= 3; f++) begin
      goto(256 * f);
      checks++; if (bus.sample_out !== 8'h80) begin errors++; $display("FAIL sq_f%0d_sample: got %h expected 80", f, bus.sample_out); end
      checks++; if (bus.edges_out !== 8'd64) begin errors++; $display("FAIL sq_f%0d_edges: got %0d expected 64", f, bus.edges_out); end
    end
    sq_en = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset(1'b1, 1'b0);
    goto(511);
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun_early: got %b expected 0", bus.overrun); end
    goto(512);
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b expected 1", bus.sample_valid); end
    checks++; if (bus.sample_out !== 8'hFE) begin errors++; $display("FAIL bp_sample_held: got %h expected fe", bus.sample_out); end
    checks++; if (bus.edges_out !== 8'd1) begin errors++; $display("FAIL bp_edges_held: got %0d expected 1", bus.edges_out); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_set: got %b expected 1", bus.overrun); end
    bus.sample_ready = 1'b1;
    goto(513);
    bus.sample_ready = 1'b0;
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL bp_consume: got %b expected 0", bus.sample_valid); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_sticky: got %b expected 1", bus.overrun); end
    bus.clear_overrun = 1'b1;
    goto(514);
    bus.clear_overrun = 1'b0;
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL bp_clear: got %b expected 0", bus.overrun); end
    goto(768);
    checks++; if (bus.sample_out !== 8'hFF) begin errors++; $display("FAIL bp_reload: got %h expected ff", bus.sample_out); end
    goto(1023);
    bus.clear_overrun = 1'b1;
    goto(1024);
    bus.clear_overrun = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL bp_set_wins: got %b expected 1", bus.overrun); end
  endtask

  task automatic test_same_cycle();
    do_reset(1'b1, 1'b0);
    goto(511);
    checks++; if (bus.sample_out !== 8'hFE) begin errors++; $display("FAIL sc_before: got %h expected fe", bus.sample_out); end
    bus.sample_ready = 1'b1;
    goto(512);
    bus.sample_ready = 1'b0;
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL sc_valid: got %b expected 1", bus.sample_valid); end
    checks++; if (bus.sample_out !== 8'hFF) begin errors++; $display("FAIL sc_sample: got %h expected ff", bus.sample_out); end
    checks++; if (bus.edges_out !== 8'd0) begin errors++; $display("FAIL sc_edges: got %0d expected 0", bus.edges_out); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL sc_overrun: got %b expected 0", bus.overrun); end
    goto(513);
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL sc_hold: got %b expected 1", bus.sample_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 1'b0);
    goto(612);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL mid_pre_overrun: got %b expected 1", bus.overrun); end
    reset   = 1'b1;
    snd_lvl = 1'b0;
    step(2);
    reset   = 1'b0;
    cyc     = 0;
    bus.sample_ready = 1'b1;
    checks++; if (bus.sample_out !== 8'h00) begin errors++; $display("FAIL mid_sample: got %h expected 00", bus.sample_out); end
    checks++; if (bus.edges_out !== 8'd0) begin errors++; $display("FAIL mid_edges: got %0d expected 0", bus.edges_out); end
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.sample_valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b expected 0", bus.overrun); end
    goto(255);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_early: got %b expected 0", bus.sample_valid); end
    goto(256);
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_new: got %b expected 1", bus.sample_valid); end
    checks++; if (bus.sample_out !== 8'h00) begin errors++; $display("FAIL mid_new_sample: got %h expected 00", bus.sample_out); end
    checks++; if (bus.edges_out !== 8'd0) begin errors++; $display("FAIL mid_new_edges: got %0d expected 0", bus.edges_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_const_low();
    test_const_high();
    test_square();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
